// File: rtl/nand2_vec_pkg.sv
// Shared types and constants for the NAND2 truth-table vector driver.
package nand2_vec_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int NUM_VEC = 4;
  localparam int CNT_W   = 4;

  function automatic logic nand_ref(input logic in_a, input logic in_b);
    return ~(in_a & in_b);
  endfunction

endpackage

// File: rtl/nand2_settle_cnt.sv
// Settle down-counter: loads a hold time and counts to zero; tick marks the sample cycle.
module nand2_settle_cnt
  import nand2_vec_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             tick
);

  logic [CNT_W-1:0] count;

  // Parks at zero once a sweep ends so no stray ticks appear in IDLE or DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

  assign tick = (count == CNT_W'(1));

endmodule

// File: rtl/nand2_vector_driver.sv
// Drives the four NAND2 input vectors, samples the gate output after a settle
// time, and reports error count, first failing vector and pass/fail.
module nand2_vector_driver
  import nand2_vec_pkg::*;
#(
  parameter int SETTLE = 2,
  parameter bit LOOP   = 1'b0
)
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       dut_o,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_cnt,
  output logic [1:0] fail_vec
);

  state_t     state;
  logic [1:0] vec_idx;
  logic       first_fail_seen;
  logic       tick;
  logic       load;
  logic       launch;
  logic       last_vec;
  logic       mismatch;
  logic [2:0] err_next;

  // A sweep launches from IDLE on start, or straight out of DONE when looping.
  assign launch   = ((state == ST_IDLE) && start) || ((state == ST_DONE) && LOOP);
  assign last_vec = (vec_idx == 2'(NUM_VEC - 1));
  assign load     = launch || ((state == ST_RUN) && tick && !last_vec);
  assign mismatch = (dut_o != nand_ref(a, b));
  assign err_next = err_cnt + 3'(mismatch);

  nand2_settle_cnt u_settle_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (CNT_W'(SETTLE)),
    .tick     (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= ST_IDLE;
      vec_idx         <= 2'd0;
      a               <= 1'b0;
      b               <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      err_cnt         <= 3'd0;
      fail_vec        <= 2'd0;
      first_fail_seen <= 1'b0;
    end else begin
      done <= 1'b0;
      if (launch) begin
        state           <= ST_RUN;
        vec_idx         <= 2'd0;
        a               <= 1'b0;
        b               <= 1'b0;
        busy            <= 1'b1;
        pass            <= 1'b0;
        err_cnt         <= 3'd0;
        fail_vec        <= 2'd0;
        first_fail_seen <= 1'b0;
      end else if ((state == ST_RUN) && tick) begin
        if (mismatch) begin
          err_cnt <= err_next;
          if (!first_fail_seen) begin
            fail_vec        <= vec_idx;
            first_fail_seen <= 1'b1;
          end
        end
        // The final vector stays on the gate inputs through DONE.
        if (last_vec) begin
          state <= ST_DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
          pass  <= (err_next == 3'd0);
        end else begin
          vec_idx <= vec_idx + 2'd1;
          {a, b}  <= vec_idx + 2'd1;
        end
      end else if (state == ST_DONE) begin
        state <= ST_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_nand2_vector_driver.sv
// Self-checking bench: random gate truth tables driven through the vector driver,
// compared against a truth-table reference model.
module tb_nand2_vector_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       dut_o;
  logic       a, b, busy, done, pass;
  logic [2:0] err_cnt;
  logic [1:0] fail_vec;
  logic [3:0] truth;

  logic       start_l;
  logic       dut_o_l;
  logic       a_l, b_l, busy_l, done_l, pass_l;
  logic [2:0] err_cnt_l;
  logic [1:0] fail_vec_l;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Gate under test modelled as a 4-entry truth table indexed by {a,b}.
  assign dut_o   = truth[{a, b}];
  assign dut_o_l = ~(a_l & b_l);

  nand2_vector_driver #(.SETTLE(2), .LOOP(1'b0)) dut (
    .clk(clk), .rst(rst), .start(start), .dut_o(dut_o),
    .a(a), .b(b), .busy(busy), .done(done), .pass(pass),
    .err_cnt(err_cnt), .fail_vec(fail_vec)
  );

  nand2_vector_driver #(.SETTLE(1), .LOOP(1'b1)) dut_loop (
    .clk(clk), .rst(rst), .start(start_l), .dut_o(dut_o_l),
    .a(a_l), .b(b_l), .busy(busy_l), .done(done_l), .pass(pass_l),
    .err_cnt(err_cnt_l), .fail_vec(fail_vec_l)
  );

  // A NAND outputs 0 only when both inputs are 1 (vector 3).
  function automatic int model_errs(input logic [3:0] tt);
    int n = 0;
    for (int v = 0; v < 4; v++)
      if (tt[v] != (v != 3)) n++;
    return n;
  endfunction

  function automatic int model_first(input logic [3:0] tt);
    for (int v = 0; v < 4; v++)
      if (tt[v] != (v != 3)) return v;
    return 0;
  endfunction

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; start_l = 1'b0; truth = 4'b0111;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({a, b, busy, done, pass, err_cnt, fail_vec} !== 10'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %b expected 0", {a, b, busy, done, pass, err_cnt, fail_vec});
    end
    checks++;
    if ({a_l, b_l, busy_l, done_l, pass_l, err_cnt_l, fail_vec_l} !== 10'd0) begin
      errors++;
      $display("[TB] FAIL reset_loop_outputs: got %b expected 0", {a_l, b_l, busy_l, done_l, pass_l, err_cnt_l, fail_vec_l});
    end
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic test_sweep(input logic [3:0] tt, input string tag);
    int exp_err = model_errs(tt);
    int exp_first = model_first(tt);
    @(negedge clk);
    truth = tt;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int j = 0; j <= 9; j++) begin
      if (j > 0) begin
        @(posedge clk);
        #1;
      end
      if (j <= 8) begin
        checks++;
        if ({a, b} !== 2'((j < 8) ? j / 2 : 3)) begin
          errors++;
          $display("[TB] FAIL %s vec j=%0d: got %b expected %0d", tag, j, {a, b}, (j < 8) ? j / 2 : 3);
        end
      end
      checks++;
      if (busy !== (j < 8)) begin
        errors++;
        $display("[TB] FAIL %s busy j=%0d: got %b expected %b", tag, j, busy, (j < 8));
      end
      checks++;
      if (done !== (j == 8)) begin
        errors++;
        $display("[TB] FAIL %s done j=%0d: got %b expected %b", tag, j, done, (j == 8));
      end
      if (j >= 8) begin
        checks++;
        if (err_cnt !== 3'(exp_err) || fail_vec !== 2'(exp_first) || pass !== (exp_err == 0)) begin
          errors++;
          $display("[TB] FAIL %s result j=%0d: got err=%0d fv=%0d pass=%b expected err=%0d fv=%0d pass=%b",
                   tag, j, err_cnt, fail_vec, pass, exp_err, exp_first, (exp_err == 0));
        end
      end
    end
    // Results must hold in IDLE until the next start.
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (err_cnt !== 3'(exp_err) || fail_vec !== 2'(exp_first) || pass !== (exp_err == 0) || done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s hold: got err=%0d fv=%0d pass=%b done=%b expected err=%0d fv=%0d pass=%b done=0",
               tag, err_cnt, fail_vec, pass, done, exp_err, exp_first, (exp_err == 0));
    end
  endtask

  task automatic test_fixed_gates();
    test_sweep(4'b0111, "nand_ok");
    test_sweep(4'b1000, "and_gate");
    test_sweep(4'b1111, "stuck_1");
    test_sweep(4'b0000, "stuck_0");
  endtask

  task automatic test_random_gates();
    for (int i = 0; i < 8; i++)
      test_sweep(4'($urandom_range(0, 15)), "random");
  endtask

  task automatic test_reset_mid_sweep();
    int done_seen = 0;
    @(negedge clk);
    truth = 4'b0111;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    #1;
    checks++;
    if ({a, b, busy, done, pass, err_cnt, fail_vec} !== 10'd0) begin
      errors++;
      $display("[TB] FAIL mid_reset_outputs: got %b expected 0", {a, b, busy, done, pass, err_cnt, fail_vec});
    end
    @(negedge clk) rst = 1'b0;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      if (done || busy) done_seen++;
    end
    checks++;
    if (done_seen !== 0) begin
      errors++;
      $display("[TB] FAIL mid_reset_quiet: got %0d active cycles expected 0", done_seen);
    end
    test_sweep(4'b0111, "after_reset");
  endtask

  task automatic test_start_held();
    int done_count = 0;
    @(negedge clk);
    truth = 4'b0111;
    start = 1'b1;
    @(posedge clk);
    for (int j = 1; j <= 10; j++) begin
      @(posedge clk);
      #1;
      if (done) done_count++;
      if (j <= 7) begin
        checks++;
        if ({a, b} !== 2'(j / 2) || busy !== 1'b1) begin
          errors++;
          $display("[TB] FAIL held_run j=%0d: got ab=%b busy=%b expected ab=%0d busy=1", j, {a, b}, busy, j / 2);
        end
      end
      if (j == 9) begin
        checks++;
        if (busy !== 1'b0) begin
          errors++;
          $display("[TB] FAIL held_idle: got busy=%b expected 0", busy);
        end
      end
    end
    checks++;
    if (done_count !== 1) begin
      errors++;
      $display("[TB] FAIL held_done_count: got %0d expected 1", done_count);
    end
    checks++;
    if (busy !== 1'b1 || {a, b} !== 2'b00 || done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL held_restart: got busy=%b ab=%b done=%b expected busy=1 ab=00 done=0", busy, {a, b}, done);
    end
    start = 1'b0;
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic test_loop();
    int active = 0;
    @(negedge clk);
    start_l = 1'b1;
    @(posedge clk);
    #1 start_l = 1'b0;
    for (int j = 0; j < 16; j++) begin
      if (j > 0) begin
        @(posedge clk);
        #1;
      end
      checks++;
      if ({a_l, b_l} !== 2'(((j % 5) < 4) ? (j % 5) : 3) || done_l !== ((j % 5) == 4) || busy_l !== ((j % 5) != 4)) begin
        errors++;
        $display("[TB] FAIL loop j=%0d: got ab=%b done=%b busy=%b expected ab=%0d done=%b busy=%b",
                 j, {a_l, b_l}, done_l, busy_l, ((j % 5) < 4) ? (j % 5) : 3, ((j % 5) == 4), ((j % 5) != 4));
      end
      if ((j % 5) == 4) begin
        checks++;
        if (pass_l !== 1'b1 || err_cnt_l !== 3'd0 || fail_vec_l !== 2'd0) begin
          errors++;
          $display("[TB] FAIL loop_result j=%0d: got pass=%b err=%0d fv=%0d expected pass=1 err=0 fv=0",
                   j, pass_l, err_cnt_l, fail_vec_l);
        end
      end
    end
    // After reset the looping instance must wait for a fresh start.
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      if (busy_l || done_l) active++;
    end
    checks++;
    if (active !== 0) begin
      errors++;
      $display("[TB] FAIL loop_reset_idle: got %0d active cycles expected 0", active);
    end
  endtask

  initial begin
    test_reset();
    test_fixed_gates();
    test_random_gates();
    test_reset_mid_sweep();
    test_start_held();
    test_loop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, expected completion before 200000");
    $fatal(1, "[TB] timeout");
  end

endmodule
